hilo_muldiv_unit: RTL and testbench

//  Multi-cycle HI/LO unit: the write side of the ALU's ALUhi/ALUlo read interface.

---
 rtl/hilo_pkg.sv | 15 +
 rtl/hilo_mul_step.sv | 18 +
 rtl/hilo_muldiv_unit.sv | 116 +++++++++++
 tb/tb_hilo_muldiv_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared op codes, FSM states and operand helper for the HI/LO unit
package hilo_pkg;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MSUB  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_DIVU  = 3'd7;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FIN = 2'd2} state_t;
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic s);
        return (s && v[31]) ? -v : v;
    endfunction
endpackage

// File: rtl/hilo_mul_step.sv
// hilo_mul_step: one K-bit shift-add multiply step on {acc, multiplier}
//   i_acc   upper product half, i_mplr lower half holding unconsumed multiplier bits
//   i_mcand multiplicand; o_acc/o_mplr the pair after retiring K multiplier bits
module hilo_mul_step #(
    parameter int K = 4
) (
    input  logic [31:0] i_acc,
    input  logic [31:0] i_mplr,
    input  logic [31:0] i_mcand,
    output logic [31:0] o_acc,
    output logic [31:0] o_mplr
);
    // acc < mcand always holds, so acc + mcand*digit fits in 32+K bits
    logic [31+K:0] w_sum;
    assign w_sum  = {{K{1'b0}}, i_acc} + ({{K{1'b0}}, i_mcand} * {{32{1'b0}}, i_mplr[K-1:0]});
    assign o_acc  = w_sum[31+K:K];
    assign o_mplr = {w_sum[K-1:0], i_mplr[31:K]};
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: architectural HI/LO registers with iterative MULT/MULTU/MADD/MSUB, MTHI/MTLO
//   Clk, Reset_n (async active-low); Op_valid/Op_ready/Op_code request handshake;
//   A, B operands; Hi, Lo architectural registers; Busy while not idle; Done pulse in FIN.
//   Define HILO_DIV_EN to add DIV/DIVU (restoring divide); otherwise codes 6/7 are no-ops.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Op_valid,
    output logic        Op_ready,
    input  logic [2:0]  Op_code,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Done
);
    localparam int ITER = 32 / BITS_PER_CYCLE;
    state_t      r_state, w_next;
    logic [4:0]  r_cnt;
    logic [2:0]  r_op;
    logic        r_neg;
    logic [31:0] r_acc, r_mplr, r_mcand, r_hi, r_lo;
    logic [31:0] w_step_acc, w_step_mplr, w_run_acc, w_run_mplr;
    logic        w_accept, w_start, w_sgn;
    logic [63:0] w_prod, w_sprod, w_mres, w_res;
    assign w_accept = Op_valid && (r_state == ST_IDLE);
    assign w_sgn    = (Op_code != OP_MULTU) && (Op_code != OP_DIVU);
    hilo_mul_step #(.K(BITS_PER_CYCLE)) u_step (
        .i_acc   (r_acc),
        .i_mplr  (r_mplr),
        .i_mcand (r_mcand),
        .o_acc   (w_step_acc),
        .o_mplr  (w_step_mplr)
    );
    assign w_prod  = {r_acc, r_mplr};
    assign w_sprod = r_neg ? -w_prod : w_prod;
    assign w_mres  = (r_op == OP_MADD) ? {r_hi, r_lo} + w_sprod :
                     (r_op == OP_MSUB) ? {r_hi, r_lo} - w_sprod : w_sprod;
`ifdef HILO_DIV_EN
    // divide reuses acc as partial remainder and mplr as dividend/quotient shift register
    logic        r_rneg;
    logic [32:0] w_div_sh, w_div_sub;
    logic        w_div_ge;
    assign w_start    = w_accept && (!Op_code[2] || Op_code[1]);
    assign w_div_sh   = {r_acc, r_mplr[31]};
    assign w_div_sub  = w_div_sh - {1'b0, r_mcand};
    assign w_div_ge   = !w_div_sub[32];
    assign w_run_acc  = r_op[2] ? (w_div_ge ? w_div_sub[31:0] : w_div_sh[31:0]) : w_step_acc;
    assign w_run_mplr = r_op[2] ? {r_mplr[30:0], w_div_ge} : w_step_mplr;
    assign w_res      = r_op[2] ? {(r_rneg ? -r_acc : r_acc),
                                   ((r_mcand == 32'd0) ? 32'hFFFFFFFF : (r_neg ? -r_mplr : r_mplr))}
                                : w_mres;
`else
    assign w_start    = w_accept && !Op_code[2];
    assign w_run_acc  = w_step_acc;
    assign w_run_mplr = w_step_mplr;
    assign w_res      = w_mres;
`endif
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end
    always_comb begin
        w_next = ST_IDLE;
        w_next = (r_state == ST_IDLE) ? (w_start ? ST_RUN : ST_IDLE) :
                 (r_state == ST_RUN)  ? ((r_cnt == 5'd0) ? ST_FIN : ST_RUN) : ST_IDLE;
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_op    <= '0;
            r_neg   <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mplr  <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef HILO_DIV_EN
            r_rneg  <= 1'b0;
`endif
        end else begin
            if (w_start) begin
                // core works on magnitudes; signs are reapplied in FIN
                r_op    <= Op_code;
                r_acc   <= '0;
                r_neg   <= w_sgn && (A[31] ^ B[31]);
                r_mplr  <= Op_code[2] ? mag32(A, w_sgn) : mag32(B, w_sgn);
                r_mcand <= Op_code[2] ? mag32(B, w_sgn) : mag32(A, w_sgn);
                r_cnt   <= Op_code[2] ? 5'd31 : 5'(ITER - 1);
`ifdef HILO_DIV_EN
                r_rneg  <= w_sgn && A[31];
`endif
            end else if (r_state == ST_RUN) begin
                r_acc  <= w_run_acc;
                r_mplr <= w_run_mplr;
                r_cnt  <= r_cnt - 5'd1;
            end
            if (w_accept && Op_code == OP_MTHI) r_hi <= A;
            if (w_accept && Op_code == OP_MTLO) r_lo <= A;
            if (r_state == ST_FIN) begin
                r_hi <= w_res[63:32];
                r_lo <= w_res[31:0];
            end
        end
    end
    assign Op_ready = (r_state == ST_IDLE);
    assign Busy     = (r_state != ST_IDLE);
    assign Done     = (r_state == ST_FIN);
    assign Hi       = r_hi;
    assign Lo       = r_lo;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;
    localparam int ITER = 8;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Op_valid;
    logic        Op_ready;
    logic [2:0]  Op_code;
    logic [31:0] A, B, Hi, Lo;
    logic        Busy, Done;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        saw_done;
    hilo_muldiv_unit #(.BITS_PER_CYCLE(4)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Op_valid (Op_valid),
        .Op_ready (Op_ready),
        .Op_code  (Op_code),
        .A        (A),
        .B        (B),
        .Hi       (Hi),
        .Lo       (Lo),
        .Busy     (Busy),
        .Done     (Done)
    );
    always #5 Clk = ~Clk;
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Op_valid = 1'b1;
        Op_code  = op;
        A        = a;
        B        = b;
        cyc();
        Op_valid = 1'b0;
        A        = 32'h1234_5678;
        B        = 32'h8765_4321;
    endtask
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] old_hi,
                         input logic [31:0] old_lo, input logic [31:0] new_hi,
                         input logic [31:0] new_lo);
        issue(op, a, b);
        chk({tag, ".busy"}, Busy, 1'b1);
        chk({tag, ".ready"}, Op_ready, 1'b0);
        repeat (lat - 1) cyc();
        chk({tag, ".nodone_early"}, Done, 1'b0);
        cyc();
        chk({tag, ".done"}, Done, 1'b1);
        chk({tag, ".hi_hold"}, Hi, old_hi);
        chk({tag, ".lo_hold"}, Lo, old_lo);
        cyc();
        chk({tag, ".done_off"}, Done, 1'b0);
        chk({tag, ".idle"}, Busy, 1'b0);
        chk({tag, ".hi"}, Hi, new_hi);
        chk({tag, ".lo"}, Lo, new_lo);
    endtask
    initial begin
        Reset_n  = 1'b0;
        Op_valid = 1'b0;
        Op_code  = OP_MULT;
        A        = '0;
        B        = '0;
        cyc();
        cyc();
        chk("rst.hi", Hi, 32'd0);
        chk("rst.lo", Lo, 32'd0);
        chk("rst.busy", Busy, 1'b0);
        chk("rst.ready", Op_ready, 1'b1);
        chk("rst.done", Done, 1'b0);
        Reset_n = 1'b1;
        cyc();
        do_op("mult", OP_MULT, 32'hFFFFFFFD, 32'd7, ITER, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        do_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, ITER,
              32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000001);
        issue(OP_MULT, 32'd5, 32'd5);
        cyc();
        cyc();
        Reset_n = 1'b0;
        #1;
        chk("midrst.hi", Hi, 32'd0);
        chk("midrst.lo", Lo, 32'd0);
        chk("midrst.busy", Busy, 1'b0);
        chk("midrst.ready", Op_ready, 1'b1);
        cyc();
        Reset_n  = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < ITER + 4; i++) begin
            cyc();
            saw_done = saw_done | Done | Busy;
        end
        chk("midrst.no_done", saw_done, 1'b0);
        chk("midrst.lo_after", Lo, 32'd0);
        Op_valid = 1'b1;
        Op_code  = OP_MTHI;
        A        = 32'd5;
        cyc();
        chk("mthi.hi", Hi, 32'd5);
        chk("mthi.busy", Busy, 1'b0);
        Op_code = OP_MTLO;
        A       = 32'd9;
        cyc();
        Op_valid = 1'b0;
        chk("mtlo.lo", Lo, 32'd9);
        chk("mtlo.hi", Hi, 32'd5);
        do_op("madd", OP_MADD, 32'd2, 32'd3, ITER, 32'd5, 32'd9, 32'd5, 32'd15);
        do_op("msub", OP_MSUB, 32'd4, 32'd4, ITER, 32'd5, 32'd15, 32'd4, 32'hFFFFFFFF);
        do_op("madd_neg", OP_MADD, 32'hFFFFFFFE, 32'd3, ITER, 32'd4, 32'hFFFFFFFF, 32'd4, 32'hFFFFFFF9);
        Op_valid = 1'b1;
        Op_code  = OP_MULT;
        A        = 32'd2;
        B        = 32'd3;
        cyc();
        Op_code  = OP_MTHI;
        A        = 32'h77;
        saw_done = 1'b0;
        for (int i = 0; i < ITER + 1; i++) begin
            saw_done = saw_done | Op_ready;
            cyc();
        end
        chk("hold.ready_low", saw_done, 1'b0);
        chk("hold.hi_not_taken", Hi, 32'd0);
        chk("hold.lo", Lo, 32'd6);
        chk("hold.ready_idle", Op_ready, 1'b1);
        cyc();
        Op_valid = 1'b0;
        chk("hold.accept_hi", Hi, 32'h77);
        chk("hold.accept_busy", Busy, 1'b0);
`ifdef HILO_DIV_EN
        do_op("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 32, 32'h77, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu0", OP_DIVU, 32'd10, 32'd0, 32, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd10, 32'hFFFFFFFF);
        do_op("divovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32, 32'd10, 32'hFFFFFFFF,
              32'd0, 32'h80000000);
        do_op("div0neg", OP_DIV, 32'hFFFFFFF0, 32'd0, 32, 32'd0, 32'h80000000,
              32'hFFFFFFF0, 32'hFFFFFFFF);
`else
        issue(OP_DIV, 32'd100, 32'd7);
        saw_done = 1'b0;
        for (int i = 0; i < 36; i++) begin
            saw_done = saw_done | Busy | Done;
            cyc();
        end
        chk("nodiv.busy", saw_done, 1'b0);
        chk("nodiv.hi", Hi, 32'h77);
        chk("nodiv.lo", Lo, 32'd6);
        chk("nodiv.ready", Op_ready, 1'b1);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
